// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic [3:0] WE_FULL    = 4'hF;
    localparam logic [3:0] STARVE_MAX = 4'hF;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;
    localparam int GNT_L = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: loader-only while booting, otherwise D over I
// unless the starve guard forces I. Output is a one-hot grant vector.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_booting,
    input  logic       i_l_req,
    input  logic       i_i_req,
    input  logic       i_d_req,
    input  logic       i_force_i,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_booting) begin
            o_gnt[GNT_L] = i_l_req;
        end else if (i_i_req && (i_force_i || !i_d_req)) begin
            o_gnt[GNT_I] = 1'b1;
        end else if (i_d_req) begin
            o_gnt[GNT_D] = 1'b1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port SRAM arbiter for fetch (I), load/store (D) and boot loader (L).
// Define MEM_ARB_STARVE_GUARD_EN to add the I starvation guard counter.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int STARVE_LIMIT  = 4,
    parameter int BOOT_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,

    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,

    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_gnt,

    input  logic          boot_done,

    output logic          i_stall,
    output logic          d_stall,

    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic          booting
);

    localparam state_e LP_RST_STATE   = (BOOT_ON_RESET != 0) ? ST_BOOT : ST_RUN;
    localparam logic   LP_RST_BOOTING = (BOOT_ON_RESET != 0);

    state_e     r_state;
    logic       r_booting;
    logic       r_rd_vld;
    owner_e     r_owner;

    logic       w_i_req;
    logic       w_d_req;
    logic       w_l_req;
    logic       w_force_i;
    logic [2:0] w_gnt;
    logic       w_d_read;
    logic       w_unused;

    // Requests are masked during reset so every command/grant output idles at 0.
    assign w_i_req = i_req & rst_n;
    assign w_d_req = d_req & rst_n;
    assign w_l_req = l_req & rst_n;

    assign w_unused = ^{i_addr[1:0], d_addr[1:0], l_addr[1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (!w_i_req || w_gnt[GNT_I]) begin
            r_starve_cnt <= '0;
        end else if (r_state == ST_RUN && r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_force_i = (r_starve_cnt >= LP_LIMIT);
`else
    assign w_force_i = 1'b0;
`endif

    mem_arb_pick u_pick (
        .i_booting (r_booting),
        .i_l_req   (w_l_req),
        .i_i_req   (w_i_req),
        .i_d_req   (w_d_req),
        .i_force_i (w_force_i),
        .o_gnt     (w_gnt)
    );

    assign i_gnt   = w_gnt[GNT_I];
    assign d_gnt   = w_gnt[GNT_D];
    assign l_gnt   = w_gnt[GNT_L];
    assign i_stall = w_i_req & ~w_gnt[GNT_I];
    assign d_stall = w_d_req & ~w_gnt[GNT_D];

    assign mem_en  = |w_gnt;

    always_comb begin
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt[GNT_L]) begin
            mem_we    = WE_FULL;
            mem_addr  = l_addr[AW-1:2];
            mem_wdata = l_wdata;
        end else if (w_gnt[GNT_D]) begin
            mem_we    = d_we;
            mem_addr  = d_addr[AW-1:2];
            mem_wdata = d_wdata;
        end else if (w_gnt[GNT_I]) begin
            mem_addr  = i_addr[AW-1:2];
        end
    end

    // BOOT lasts until the cycle after boot_done; a same-cycle L write still lands in BOOT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LP_RST_STATE;
            r_booting <= LP_RST_BOOTING;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    if (boot_done) begin
                        r_state   <= ST_RUN;
                        r_booting <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_state   <= ST_RUN;
                    r_booting <= 1'b0;
                end
                default: begin
                    r_state   <= LP_RST_STATE;
                    r_booting <= LP_RST_BOOTING;
                end
            endcase
        end
    end

    assign booting  = r_booting;

    assign w_d_read = w_gnt[GNT_D] & (d_we == 4'h0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_owner  <= OWN_I;
        end else begin
            r_rd_vld <= w_gnt[GNT_I] | w_d_read;
            if (w_gnt[GNT_I]) begin
                r_owner <= OWN_I;
            end else if (w_gnt[GNT_D]) begin
                r_owner <= OWN_D;
            end
        end
    end

    // Read data is shared; only the valid strobe is steered to the owning port.
    assign i_rvalid = r_rd_vld & (r_owner == OWN_I);
    assign d_rvalid = r_rd_vld & (r_owner == OWN_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed table, starve sequence,
// randomized traffic against a transaction-level model, and mid-read reset.
module tb_unified_mem_arbiter;

    localparam int AW    = 32;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req = 0, d_req = 0, l_req = 0, boot_done = 0;
    logic [AW-1:0] i_addr = 0, d_addr = 0, l_addr = 0;
    logic [3:0]    d_we = 0;
    logic [31:0]   d_wdata = 0, l_wdata = 0;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, l_gnt;
    logic [31:0]   i_rdata, d_rdata;
    logic          i_stall, d_stall, mem_en, booting;
    logic [3:0]    mem_we;
    logic [AW-3:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .STARVE_LIMIT(LIMIT), .BOOT_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
        .boot_done(boot_done), .i_stall(i_stall), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .booting(booting)
    );

    // Behavioural SRAM, 64 words, one-cycle read latency, cleared while in reset.
    logic [31:0] sram [0:63];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 64; k++) sram[k] <= '0;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we == 4'h0) mem_rdata <= sram[mem_addr[5:0]];
            else for (int b = 0; b < 4; b++)
                if (mem_we[b]) sram[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: mode, consecutive I denials, expected read response, memory image.
    bit          m_boot;
    int          m_wait;
    bit          m_pend;
    bit          m_pend_d;
    logic [31:0] m_pend_data;
    logic [31:0] ref_mem [0:63];

    task automatic model_reset();
        m_boot = 1'b1;
        m_wait = 0;
        m_pend = 1'b0;
        m_pend_d = 1'b0;
        m_pend_data = '0;
        for (int k = 0; k < 64; k++) ref_mem[k] = '0;
    endtask

    // Winner code: 0 none, 1 I, 2 D, 3 L.
    task automatic check_cycle(output int w);
        logic [3:0]  ewe;
        logic [29:0] ea;
        logic [31:0] ewd;
        bit          forced;
        #3;
        forced = GUARD && (m_wait >= LIMIT);
        w = 0;
        if (m_boot) begin
            if (l_req) w = 3;
        end else if (i_req && (forced || !d_req)) w = 1;
        else if (d_req) w = 2;
        ewe = '0; ea = '0; ewd = '0;
        case (w)
            1: ea = i_addr[31:2];
            2: begin ewe = d_we; ea = d_addr[31:2]; ewd = d_wdata; end
            3: begin ewe = 4'hF; ea = l_addr[31:2]; ewd = l_wdata; end
            default: ;
        endcase
        chk("gnt/stall/en", {i_gnt, d_gnt, l_gnt, i_stall, d_stall, mem_en},
            {w == 1, w == 2, w == 3, i_req && w != 1, d_req && w != 2, w != 0});
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, ea);
        if (ewe != 4'h0) chk("mem_wdata", mem_wdata, ewd);
        chk("rvalid", {i_rvalid, d_rvalid}, {m_pend && !m_pend_d, m_pend && m_pend_d});
        if (m_pend) chk("rdata", m_pend_d ? d_rdata : i_rdata, m_pend_data);
        chk("booting", booting, m_boot);
    endtask

    task automatic advance(input int w);
        m_pend   = (w == 1) || (w == 2 && d_we == 4'h0);
        m_pend_d = (w == 2);
        if (w == 1) m_pend_data = ref_mem[i_addr[7:2]];
        if (w == 2) m_pend_data = ref_mem[d_addr[7:2]];
        if (w == 3) ref_mem[l_addr[7:2]] = l_wdata;
        if (w == 2 && d_we != 4'h0)
            for (int b = 0; b < 4; b++)
                if (d_we[b]) ref_mem[d_addr[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
        if (!i_req || w == 1) m_wait = 0;
        else if (!m_boot && m_wait < 15) m_wait++;
        if (m_boot && boot_done) m_boot = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {i_gnt, d_gnt, l_gnt, i_stall, d_stall, mem_en, i_rvalid, d_rvalid, mem_we}, '0);
        chk({nm, " booting"}, booting, 1'b1);
    endtask

    typedef struct {
        logic        i_req, d_req, l_req, boot_done;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [2:0]  exp_gnt;   // {l, d, i}
        logic [3:0]  exp_we;
        logic [29:0] exp_maddr;
        logic        exp_boot;  // booting after the edge
    } vec_t;

    vec_t tbl [12];

    initial begin
        int w;
        bit i_hold, d_hold;

        tbl[0]  = '{1, 0, 0, 0, 32'h00, 4'h0, 32'h0,        3'b000, 4'h0, 30'd0, 1};
        tbl[1]  = '{0, 0, 1, 0, 32'h10, 4'h0, 32'hDEADBEEF, 3'b100, 4'hF, 30'd4, 1};
        tbl[2]  = '{0, 1, 0, 0, 32'h20, 4'h0, 32'h0,        3'b000, 4'h0, 30'd0, 1};
        tbl[3]  = '{0, 0, 1, 1, 32'h13, 4'h0, 32'h12345678, 3'b100, 4'hF, 30'd4, 0};
        tbl[4]  = '{0, 1, 0, 0, 32'h10, 4'h0, 32'h0,        3'b010, 4'h0, 30'd4, 0};
        tbl[5]  = '{0, 0, 1, 0, 32'h40, 4'h0, 32'h55,       3'b000, 4'h0, 30'd0, 0};
        tbl[6]  = '{0, 1, 0, 0, 32'h07, 4'h2, 32'h0000AB00, 3'b010, 4'h2, 30'd1, 0};
        tbl[7]  = '{1, 0, 0, 0, 32'h10, 4'h0, 32'h0,        3'b001, 4'h0, 30'd4, 0};
        tbl[8]  = '{1, 1, 0, 0, 32'h04, 4'h0, 32'h0,        3'b010, 4'h0, 30'd1, 0};
        tbl[9]  = '{1, 0, 0, 0, 32'h04, 4'h0, 32'h0,        3'b001, 4'h0, 30'd1, 0};
        tbl[10] = '{0, 1, 0, 0, 32'h07, 4'h0, 32'h0,        3'b010, 4'h0, 30'd1, 0};
        tbl[11] = '{0, 0, 0, 0, 32'h00, 4'h0, 32'h0,        3'b000, 4'h0, 30'd0, 0};

        // Reset with every request asserted: outputs must stay at reset values.
        i_req = 1; d_req = 1; l_req = 1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset outputs");
        i_req = 0; d_req = 0; l_req = 0;
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[n]) begin
            i_req = tbl[n].i_req; d_req = tbl[n].d_req; l_req = tbl[n].l_req;
            boot_done = tbl[n].boot_done;
            i_addr = tbl[n].addr; d_addr = tbl[n].addr; l_addr = tbl[n].addr;
            d_we = tbl[n].we; d_wdata = tbl[n].wdata; l_wdata = tbl[n].wdata;
            check_cycle(w);
            chk("tbl grant", {l_gnt, d_gnt, i_gnt}, tbl[n].exp_gnt);
            chk("tbl mem_we", mem_we, tbl[n].exp_we);
            chk("tbl mem_addr", mem_addr, tbl[n].exp_maddr);
            advance(w);
            chk("tbl booting", booting, tbl[n].exp_boot);
        end
        boot_done = 0;

        // I and D held continuously.
        i_req = 1; d_req = 1; d_we = 0; i_addr = 32'h20; d_addr = 32'h24;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 20; k++) begin
            check_cycle(w);
            chk("starve i_gnt", i_gnt, (k % 5) == 4);
            chk("starve d_gnt", d_gnt, (k % 5) != 4);
            advance(w);
        end
`else
        for (int k = 0; k < 100; k++) begin
            check_cycle(w);
            chk("no-guard i_gnt", i_gnt, 1'b0);
            advance(w);
        end
`endif
        i_req = 0; d_req = 0;
        check_cycle(w);
        advance(w);

        // Randomized traffic; a denied requester holds its request unchanged.
        i_hold = 0; d_hold = 0;
        for (int k = 0; k < 400; k++) begin
            if (!i_hold) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = 32'($urandom_range(0, 255));
            end
            if (!d_hold) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_addr  = 32'($urandom_range(0, 255));
                d_we    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                d_wdata = $urandom;
            end
            l_req   = $urandom_range(0, 1);
            l_addr  = 32'($urandom_range(0, 255));
            l_wdata = $urandom;
            check_cycle(w);
            i_hold = i_req && (w != 1);
            d_hold = d_req && (w != 2);
            advance(w);
        end

        // Reset just after an I read grant: the pending response is dropped.
        i_req = 1; i_addr = 32'h8; d_req = 0; l_req = 0;
        check_cycle(w);
        chk("pre-reset i_gnt", i_gnt, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        i_req = 1; d_req = 1; l_req = 1;
        #2 chk_reset_outputs("mid-op reset");
        repeat (2) @(negedge clk);
        chk_reset_outputs("held reset");
        i_req = 0; d_req = 0; l_req = 0;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check_cycle(w);
            chk("post-reset i_rvalid", i_rvalid, 1'b0);
            advance(w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
